// File: rtl/pause_frame_tx.sv
//-----------------------------------------------------------------------------
// pause_frame_tx
//
// Builds IEEE 802.3x MAC Control PAUSE frames on the clk_125 transmit side.
// An XOFF frame goes out while the local receive path reports congestion.
// The XOFF is re-sent periodically while congestion persists. The block emits
// only the 60-byte frame body; tx_mac adds the preamble, SFD and FCS.
//
// Build option:
//   PAUSE_FRAME_XON_EN  when defined, an XON frame (pause_time 0000) is sent
//                       when congestion clears. When undefined, the block
//                       returns to idle and lets the link partner time out.
//
// Ports:
//   clk               clk_125 domain clock
//   reset_n           asynchronous active-low reset
//   pause_req         congestion level from the receive FIFO (already synced)
//   cfg_quanta        runtime pause_time for XOFF frames
//   cfg_quanta_valid  selects cfg_quanta instead of DEFAULT_QUANTA
//   m_axis_tdata      frame byte
//   m_axis_tvalid     byte valid
//   m_axis_tlast      last byte of the frame (index 59)
//   m_axis_trdy       downstream accepts the current byte
//   tx_pause          high while any pause frame is on the stream
//   pause_active      high from an XOFF tlast until the pause is released
//-----------------------------------------------------------------------------
module pause_frame_tx #(
   parameter logic [47:0] SRC_MAC        = 48'h02_00_00_00_00_01,
   parameter logic [15:0] DEFAULT_QUANTA = 16'hFFFF,
   parameter logic [23:0] REFRESH_CYCLES = 24'd2_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        pause_req,
   input  logic [15:0] cfg_quanta,
   input  logic        cfg_quanta_valid,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_trdy,
   output logic        tx_pause,
   output logic        pause_active
);

   localparam logic [5:0] LAST_IDX = 6'd59;

`ifdef PAUSE_FRAME_XON_EN
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEND_XOFF = 2'd1,
      ST_HOLDOFF   = 2'd2,
      ST_SEND_XON  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEND_XOFF = 2'd1,
      ST_HOLDOFF   = 2'd2
   } state_t;
`endif

   state_t      state_r, state_s;
   logic [5:0]  byte_cnt_r, byte_cnt_s;
   logic [23:0] refresh_cnt_r, refresh_cnt_s;
   logic [15:0] quanta_r, quanta_s;
   logic [7:0]  tdata_r, tdata_s;
   logic        tvalid_r, tvalid_s;
   logic        tlast_r, tlast_s;
   logic        tx_pause_r, tx_pause_s;
   logic        pause_active_r, pause_active_s;
   logic        xfer_s;
   logic [15:0] xoff_quanta_s;

   // Frame body byte for a given index; pause_time is the latched value.
   function automatic logic [7:0] frame_byte(input logic [5:0] idx,
                                             input logic [15:0] quanta);
      logic [7:0] b;
      case (idx)
         6'd0:    b = 8'h01;
         6'd1:    b = 8'h80;
         6'd2:    b = 8'hC2;
         6'd3:    b = 8'h00;
         6'd4:    b = 8'h00;
         6'd5:    b = 8'h01;
         6'd6:    b = SRC_MAC[47:40];
         6'd7:    b = SRC_MAC[39:32];
         6'd8:    b = SRC_MAC[31:24];
         6'd9:    b = SRC_MAC[23:16];
         6'd10:   b = SRC_MAC[15:8];
         6'd11:   b = SRC_MAC[7:0];
         6'd12:   b = 8'h88;
         6'd13:   b = 8'h08;
         6'd14:   b = 8'h00;
         6'd15:   b = 8'h01;
         6'd16:   b = quanta[15:8];
         6'd17:   b = quanta[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign xfer_s        = tvalid_r && m_axis_trdy;
   assign xoff_quanta_s = cfg_quanta_valid ? cfg_quanta : DEFAULT_QUANTA;

   // Next-state and next-output computation for every registered signal.
   always_comb begin
      state_s        = state_r;
      byte_cnt_s     = byte_cnt_r;
      refresh_cnt_s  = refresh_cnt_r;
      quanta_s       = quanta_r;
      tdata_s        = tdata_r;
      tvalid_s       = tvalid_r;
      tlast_s        = tlast_r;
      tx_pause_s     = tx_pause_r;
      pause_active_s = pause_active_r;

      case (state_r)
         ST_IDLE: begin
            if (pause_req) begin
               state_s    = ST_SEND_XOFF;
               quanta_s   = xoff_quanta_s;
               byte_cnt_s = 6'd0;
            end else begin
               state_s    = ST_IDLE;
            end
         end

`ifdef PAUSE_FRAME_XON_EN
         ST_SEND_XOFF, ST_SEND_XON: begin
`else
         ST_SEND_XOFF: begin
`endif
            // The first cycle in a send state only raises tvalid, so the
            // stream always shows at least one idle cycle between frames.
            if (!tvalid_r) begin
               tvalid_s   = 1'b1;
               tx_pause_s = 1'b1;
               byte_cnt_s = 6'd0;
               tdata_s    = frame_byte(6'd0, quanta_r);
               tlast_s    = 1'b0;
            end else if (xfer_s) begin
               if (byte_cnt_r == LAST_IDX) begin
                  tvalid_s   = 1'b0;
                  tx_pause_s = 1'b0;
                  tlast_s    = 1'b0;
                  tdata_s    = 8'h00;
                  byte_cnt_s = 6'd0;
                  if (state_r == ST_SEND_XOFF) begin
                     state_s        = ST_HOLDOFF;
                     refresh_cnt_s  = REFRESH_CYCLES - 24'd1;
                     pause_active_s = 1'b1;
                  end else begin
                     state_s        = ST_IDLE;
                     pause_active_s = 1'b0;
                  end
               end else begin
                  byte_cnt_s = byte_cnt_r + 6'd1;
                  tdata_s    = frame_byte(byte_cnt_r + 6'd1, quanta_r);
                  tlast_s    = ((byte_cnt_r + 6'd1) == LAST_IDX);
               end
            end else begin
               // Stalled: hold the presented byte unchanged.
               tvalid_s = 1'b1;
            end
         end

         ST_HOLDOFF: begin
            // A released pause_req wins over a refresh falling due.
            if (!pause_req) begin
               refresh_cnt_s = 24'd0;
`ifdef PAUSE_FRAME_XON_EN
               state_s       = ST_SEND_XON;
               quanta_s      = 16'h0000;
               byte_cnt_s    = 6'd0;
`else
               state_s        = ST_IDLE;
               pause_active_s = 1'b0;
`endif
            end else if (refresh_cnt_r == 24'd0) begin
               state_s    = ST_SEND_XOFF;
               quanta_s   = xoff_quanta_s;
               byte_cnt_s = 6'd0;
            end else begin
               refresh_cnt_s = refresh_cnt_r - 24'd1;
            end
         end

         default: begin
            state_s        = ST_IDLE;
            byte_cnt_s     = 6'd0;
            refresh_cnt_s  = 24'd0;
            quanta_s       = 16'h0000;
            tdata_s        = 8'h00;
            tvalid_s       = 1'b0;
            tlast_s        = 1'b0;
            tx_pause_s     = 1'b0;
            pause_active_s = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears everything at once, so a
   // frame in flight is simply truncated.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= ST_IDLE;
         byte_cnt_r     <= 6'd0;
         refresh_cnt_r  <= 24'd0;
         quanta_r       <= 16'h0000;
         tdata_r        <= 8'h00;
         tvalid_r       <= 1'b0;
         tlast_r        <= 1'b0;
         tx_pause_r     <= 1'b0;
         pause_active_r <= 1'b0;
      end else begin
         state_r        <= state_s;
         byte_cnt_r     <= byte_cnt_s;
         refresh_cnt_r  <= refresh_cnt_s;
         quanta_r       <= quanta_s;
         tdata_r        <= tdata_s;
         tvalid_r       <= tvalid_s;
         tlast_r        <= tlast_s;
         tx_pause_r     <= tx_pause_s;
         pause_active_r <= pause_active_s;
      end
   end

   assign m_axis_tdata  = tdata_r;
   assign m_axis_tvalid = tvalid_r;
   assign m_axis_tlast  = tlast_r;
   assign tx_pause      = tx_pause_r;
   assign pause_active  = pause_active_r;

   pause_frame_tx_chk u_chk (
      .clk           (clk),
      .reset_n       (reset_n),
      .m_axis_tdata  (tdata_r),
      .m_axis_tvalid (tvalid_r),
      .m_axis_tlast  (tlast_r),
      .m_axis_trdy   (m_axis_trdy),
      .tx_pause      (tx_pause_r)
   );

endmodule

//-----------------------------------------------------------------------------
// pause_frame_tx_chk
//
// Protocol properties of the pause frame stream.
// Ports: clk, reset_n, and the AXI-Stream outputs plus tx_pause of the block.
//-----------------------------------------------------------------------------
module pause_frame_tx_chk (
   input logic       clk,
   input logic       reset_n,
   input logic [7:0] m_axis_tdata,
   input logic       m_axis_tvalid,
   input logic       m_axis_tlast,
   input logic       m_axis_trdy,
   input logic       tx_pause
);

   // A stalled byte must stay presented and unchanged.
   a_hold_on_stall: assert property (@(posedge clk) disable iff (!reset_n)
      (m_axis_tvalid && !m_axis_trdy) |=>
      (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tlast)));

   // tlast only ever accompanies a valid byte.
   a_tlast_valid: assert property (@(posedge clk) disable iff (!reset_n)
      m_axis_tlast |-> m_axis_tvalid);

   // tx_pause covers exactly the cycles a frame is on the stream.
   a_tx_pause: assert property (@(posedge clk) disable iff (!reset_n)
      tx_pause == m_axis_tvalid);

endmodule

// File: tb/tb_pause_frame_tx.sv
module tb_pause_frame_tx;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        pause_req = 1'b0;
   logic [15:0] cfg_quanta = 16'h0000;
   logic        cfg_quanta_valid = 1'b0;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_trdy = 1'b1;
   logic        tx_pause;
   logic        pause_active;

   int total = 0;
   int bad   = 0;
   logic [7:0] got [60];

   typedef struct {
      logic [15:0] q;
      logic        qv;
      int          chg_at;
      logic [15:0] chg_val;
      bit          stall;
      logic [7:0]  e16;
      logic [7:0]  e17;
   } vec_t;

   vec_t vecs [4];

   pause_frame_tx #(.REFRESH_CYCLES(24'd100)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .pause_req        (pause_req),
      .cfg_quanta       (cfg_quanta),
      .cfg_quanta_valid (cfg_quanta_valid),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tlast     (m_axis_tlast),
      .m_axis_trdy      (m_axis_trdy),
      .tx_pause         (tx_pause),
      .pause_active     (pause_active)
   );

   always #4 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference frame: destination, source, type/opcode, pause_time, zero pad.
   function automatic logic [7:0] model_byte(input int idx, input logic [15:0] q);
      logic [47:0] dst;
      logic [47:0] src;
      logic [47:0] ctl;
      logic [47:0] pt;
      logic [47:0] sh;
      dst = 48'h01_80_C2_00_00_01;
      src = 48'h02_00_00_00_00_01;
      ctl = {16'h0000, 32'h8808_0001};
      pt  = {32'h0000_0000, q};
      if (idx < 6)       sh = dst >> (8 * (5 - idx));
      else if (idx < 12) sh = src >> (8 * (11 - idx));
      else if (idx < 16) sh = ctl >> (8 * (15 - idx));
      else if (idx < 18) sh = pt >> (8 * (17 - idx));
      else               sh = 48'h0;
      return sh[7:0];
   endfunction

   // Waits for a frame, receives it (optionally with random stalls) and
   // compares it with the reference frame.
   task automatic run_frame(input logic [15:0] exp_q, input bit req_after, input bit stall,
                            input int chg_at, input logic [15:0] chg_val, input logic exp_pa);
      int         wait_c;
      int         n;
      int         cyc;
      bit         prev_stall;
      logic [7:0] prev_d;
      logic       prev_l;
      wait_c = 0;
      while (!m_axis_tvalid && wait_c < 50) begin
         step();
         wait_c++;
      end
      check("frame_start", 32'(m_axis_tvalid), 32'd1);
      if (m_axis_tvalid) begin
         pause_req  = req_after;
         n          = 0;
         cyc        = 0;
         prev_stall = 1'b0;
         prev_d     = 8'h00;
         prev_l     = 1'b0;
         while (n < 60 && cyc < 2000) begin
            if (prev_stall) begin
               check("stall_tdata_hold", 32'(m_axis_tdata), 32'(prev_d));
               check("stall_tlast_hold", 32'(m_axis_tlast), 32'(prev_l));
            end
            check("tvalid_steady", 32'(m_axis_tvalid), 32'd1);
            check("tx_pause_in_frame", 32'(tx_pause), 32'd1);
            check("pause_active_in_frame", 32'(pause_active), 32'(exp_pa));
            if (n == chg_at) cfg_quanta = chg_val;
            m_axis_trdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            prev_stall  = m_axis_tvalid && !m_axis_trdy;
            prev_d      = m_axis_tdata;
            prev_l      = m_axis_tlast;
            if (m_axis_tvalid && m_axis_trdy) begin
               got[n] = m_axis_tdata;
               check($sformatf("tlast_at_%0d", n), 32'(m_axis_tlast), 32'(n == 59));
               n++;
            end
            step();
            cyc++;
         end
         m_axis_trdy = 1'b1;
         check("transfer_count", 32'(n), 32'd60);
         for (int i = 0; i < 60; i++)
            check($sformatf("frame_byte_%0d", i), 32'(got[i]), 32'(model_byte(i, exp_q)));
         check("tvalid_gap_after_tlast", 32'(m_axis_tvalid), 32'd0);
         check("tx_pause_after_tlast", 32'(tx_pause), 32'd0);
      end
   endtask

   // Called on the cycle after an XOFF tlast with pause_req already low.
   task automatic end_seq();
      check("pause_active_after_xoff", 32'(pause_active), 32'd1);
`ifdef PAUSE_FRAME_XON_EN
      run_frame(16'h0000, 1'b0, 1'b0, -1, 16'h0000, 1'b1);
      check("xon_quanta_hi", 32'(got[16]), 32'h00);
      check("xon_quanta_lo", 32'(got[17]), 32'h00);
      check("pause_active_after_xon", 32'(pause_active), 32'd0);
`else
      step();
      check("pause_active_clear_no_xon", 32'(pause_active), 32'd0);
      repeat (5) step();
      check("no_xon_frame", 32'(m_axis_tvalid), 32'd0);
`endif
   endtask

   initial begin
      int          c;
      int          idx;
      logic [15:0] q;
      logic        qv;

      vecs[0] = '{q: 16'h1234, qv: 1'b1, chg_at: 10, chg_val: 16'h0055, stall: 1'b0, e16: 8'h12, e17: 8'h34};
      vecs[1] = '{q: 16'h1234, qv: 1'b0, chg_at: -1, chg_val: 16'h0000, stall: 1'b0, e16: 8'hFF, e17: 8'hFF};
      vecs[2] = '{q: 16'h00AB, qv: 1'b1, chg_at: 5,  chg_val: 16'hFFFF, stall: 1'b1, e16: 8'h00, e17: 8'hAB};
      vecs[3] = '{q: 16'h8001, qv: 1'b1, chg_at: -1, chg_val: 16'h0000, stall: 1'b1, e16: 8'h80, e17: 8'h01};

      // Reset with pause_req held high.
      pause_req = 1'b1;
      #2 reset_n = 1'b0;
      repeat (3) step();
      check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_tlast", 32'(m_axis_tlast), 32'd0);
      check("rst_tdata", 32'(m_axis_tdata), 32'd0);
      check("rst_tx_pause", 32'(tx_pause), 32'd0);
      check("rst_pause_active", 32'(pause_active), 32'd0);
      reset_n = 1'b1;

      // First XOFF with default quanta, pause_req stays high.
      run_frame(16'hFFFF, 1'b1, 1'b0, -1, 16'h0000, 1'b0);
      check("first_b12", 32'(got[12]), 32'h88);
      check("first_b13", 32'(got[13]), 32'h08);
      check("first_b15", 32'(got[15]), 32'h01);
      check("first_b16", 32'(got[16]), 32'hFF);
      check("first_b17", 32'(got[17]), 32'hFF);
      check("pause_active_holdoff", 32'(pause_active), 32'd1);

      // Refresh: tvalid returns REFRESH_CYCLES + 1 cycles after the tlast.
      c = 0;
      while (!m_axis_tvalid && c < 300) begin
         step();
         c++;
      end
      check("refresh_gap_cycles", 32'(c), 32'd101);
      check("pause_active_refresh", 32'(pause_active), 32'd1);
      pause_req = 1'b0;
      run_frame(16'hFFFF, 1'b0, 1'b0, -1, 16'h0000, 1'b1);
      end_seq();

      // Table-driven frames.
      for (int v = 0; v < 4; v++) begin
         cfg_quanta       = vecs[v].q;
         cfg_quanta_valid = vecs[v].qv;
         pause_req        = 1'b1;
         run_frame(vecs[v].qv ? vecs[v].q : 16'hFFFF, 1'b0, vecs[v].stall,
                   vecs[v].chg_at, vecs[v].chg_val, 1'b0);
         check($sformatf("vec%0d_b16", v), 32'(got[16]), 32'(vecs[v].e16));
         check($sformatf("vec%0d_b17", v), 32'(got[17]), 32'(vecs[v].e17));
         end_seq();
      end

      // Random quanta with random backpressure.
      for (int r = 0; r < 6; r++) begin
         q                = 16'($urandom);
         qv               = 1'($urandom_range(0, 1));
         cfg_quanta       = q;
         cfg_quanta_valid = qv;
         pause_req        = 1'b1;
         run_frame(qv ? q : 16'hFFFF, 1'b0, 1'b1, -1, 16'h0000, 1'b0);
         end_seq();
      end

      // Reset while byte 30 is presented.
      cfg_quanta_valid = 1'b0;
      pause_req        = 1'b1;
      idx              = 0;
      c                = 0;
      while (!(m_axis_tvalid && idx == 30) && c < 300) begin
         m_axis_trdy = 1'b1;
         if (m_axis_tvalid && m_axis_trdy) idx++;
         step();
         c++;
      end
      check("reached_byte30", 32'(idx), 32'd30);
      reset_n = 1'b0;
      #1;
      check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("midrst_tx_pause", 32'(tx_pause), 32'd0);
      check("midrst_tlast", 32'(m_axis_tlast), 32'd0);
      repeat (3) step();
      check("midrst_hold_tvalid", 32'(m_axis_tvalid), 32'd0);
      reset_n = 1'b1;
      run_frame(16'hFFFF, 1'b0, 1'b0, -1, 16'h0000, 1'b0);
      check("fresh_frame_b0", 32'(got[0]), 32'h01);
      end_seq();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
